// File: rtl/ifid_pipe_reg.sv
// ============================================================================
// Module   : ifid_pipe_reg
// Purpose  : PC register and IF/ID pipeline register driven by hazard-unit
//            enables, with a RUN/STALL/FLUSH tracker and a sticky stall
//            watchdog. Define IFID_PERF_CNT_EN to build stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifid_pipe_reg #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MAX_STALL = 8,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_next_i,
  input  logic [31:0] instr_i,
  input  logic        PCWrite_i,
  input  logic        IFIDWrite_i,
  input  logic        IFFlush_i,
  output logic [31:0] pc_o,
  output logic [31:0] IFID_pc_o,
  output logic [31:0] IFID_instr_o,
  output logic        IFID_valid_o,
  output logic [1:0]  state_o,
  output logic        stall_err_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_BAD   = 2'd3
  } state_t;

  localparam logic [7:0] c_max_stall = 8'(MAX_STALL);

  logic [31:0] r_pc;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_instr;
  logic        r_ifid_valid;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_run_len;
  logic        r_stall_err;

  always_comb begin
    w_state_nxt = ST_RUN;
    if (r_state == ST_BAD)
      w_state_nxt = ST_RUN;
    else if (IFFlush_i)
      w_state_nxt = ST_FLUSH;
    else if (!PCWrite_i && !IFIDWrite_i)
      w_state_nxt = ST_STALL;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc <= RESET_PC;
    end else if (PCWrite_i) begin
      r_pc <= pc_next_i;
    end
  end

  // Flush outranks the write enable so a squashed fetch never reaches decode.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ifid_pc    <= 32'h0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else if (IFFlush_i) begin
      r_ifid_pc    <= 32'h0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else if (IFIDWrite_i) begin
      r_ifid_pc    <= r_pc + 32'd4;
      r_ifid_instr <= instr_i;
      r_ifid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= ST_RUN;
      r_run_len   <= 8'd0;
      r_stall_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt == ST_STALL) begin
        if (r_run_len != c_max_stall)
          r_run_len <= r_run_len + 8'd1;
        if (r_run_len >= c_max_stall - 8'd1)
          r_stall_err <= 1'b1;
      end else begin
        r_run_len <= 8'd0;
      end
    end
  end

`ifdef IFID_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= 32'h0;
      r_flush_cnt <= 32'h0;
    end else begin
      if (w_state_nxt == ST_STALL)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_state_nxt == ST_FLUSH)
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = 32'h0;
  assign flush_cnt_o = 32'h0;
`endif

  assign pc_o         = r_pc;
  assign IFID_pc_o    = r_ifid_pc;
  assign IFID_instr_o = r_ifid_instr;
  assign IFID_valid_o = r_ifid_valid;
  assign state_o      = r_state;
  assign stall_err_o  = r_stall_err;

endmodule

`default_nettype wire

// File: tb/tb_ifid_pipe_reg.sv
// ============================================================================
// Module   : tb_ifid_pipe_reg
// Purpose  : Directed vector bench for ifid_pipe_reg (watchdog, wrap, reset).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifid_pipe_reg;

  localparam logic [31:0] c_nop = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] pc_next_i = 32'h0;
  logic [31:0] instr_i = 32'h0;
  logic        PCWrite_i = 1'b0;
  logic        IFIDWrite_i = 1'b0;
  logic        IFFlush_i = 1'b0;
  logic [31:0] pc_o, IFID_pc_o, IFID_instr_o, stall_cnt_o, flush_cnt_o;
  logic        IFID_valid_o, stall_err_o;
  logic [1:0]  state_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_scnt = 32'h0;
  logic [31:0] exp_fcnt = 32'h0;

  ifid_pipe_reg #(
    .RESET_PC (32'h0000_0000),
    .MAX_STALL(8),
    .NOP_INSTR(c_nop)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pc_next_i   (pc_next_i),
    .instr_i     (instr_i),
    .PCWrite_i   (PCWrite_i),
    .IFIDWrite_i (IFIDWrite_i),
    .IFFlush_i   (IFFlush_i),
    .pc_o        (pc_o),
    .IFID_pc_o   (IFID_pc_o),
    .IFID_instr_o(IFID_instr_o),
    .IFID_valid_o(IFID_valid_o),
    .state_o     (state_o),
    .stall_err_o (stall_err_o),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pn;
    logic [31:0] in;
    logic        pw;
    logic        iw;
    logic        fl;
    logic [31:0] epc;
    logic [31:0] eipc;
    logic [31:0] einst;
    logic        ev;
    logic [1:0]  est;
    logic        eerr;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] epc, input logic [31:0] eipc,
                           input logic [31:0] einst, input logic ev, input logic [1:0] est,
                           input logic eerr);
    chk({tag, ".pc"},    pc_o, epc);
    chk({tag, ".ifpc"},  IFID_pc_o, eipc);
    chk({tag, ".instr"}, IFID_instr_o, einst);
    chk({tag, ".valid"}, {31'h0, IFID_valid_o}, {31'h0, ev});
    chk({tag, ".state"}, {30'h0, state_o}, {30'h0, est});
    chk({tag, ".err"},   {31'h0, stall_err_o}, {31'h0, eerr});
`ifdef IFID_PERF_CNT_EN
    chk({tag, ".scnt"},  stall_cnt_o, exp_scnt);
    chk({tag, ".fcnt"},  flush_cnt_o, exp_fcnt);
`else
    chk({tag, ".scnt"},  stall_cnt_o, 32'h0);
    chk({tag, ".fcnt"},  flush_cnt_o, 32'h0);
`endif
  endtask

  // Apply one cycle of inputs, then compare against hand-computed outputs.
  task automatic step(input string tag, input vec_t v);
    @(negedge clk_i);
    pc_next_i   = v.pn;
    instr_i     = v.in;
    PCWrite_i   = v.pw;
    IFIDWrite_i = v.iw;
    IFFlush_i   = v.fl;
    @(posedge clk_i);
    #1;
    if (v.est == 2'd1) exp_scnt = exp_scnt + 32'd1;
    if (v.est == 2'd2) exp_fcnt = exp_fcnt + 32'd1;
    check_all(tag, v.epc, v.eipc, v.einst, v.ev, v.est, v.eerr);
  endtask

  initial begin
    vec_t v;
    //           pn            in            pw    iw    fl    epc           eipc          einst         ev    est   eerr
    vecs[0]  = '{32'h4,        32'h2001_0005, 1'b1, 1'b1, 1'b0, 32'h4,        32'h4,        32'h2001_0005, 1'b1, 2'd0, 1'b0};
    vecs[1]  = '{32'h8,        32'h2002_0007, 1'b1, 1'b1, 1'b0, 32'h8,        32'h8,        32'h2002_0007, 1'b1, 2'd0, 1'b0};
    vecs[2]  = '{32'hC,        32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h8,        32'h8,        32'h2002_0007, 1'b1, 2'd1, 1'b0};
    vecs[3]  = '{32'hC,        32'h2003_0009, 1'b1, 1'b1, 1'b0, 32'hC,        32'hC,        32'h2003_0009, 1'b1, 2'd0, 1'b0};
    vecs[4]  = '{32'h40,       32'h1111_1111, 1'b1, 1'b1, 1'b1, 32'h40,       32'h0,        c_nop,         1'b0, 2'd2, 1'b0};
    vecs[5]  = '{32'h44,       32'h2004_0001, 1'b1, 1'b1, 1'b0, 32'h44,       32'h44,       32'h2004_0001, 1'b1, 2'd0, 1'b0};
    vecs[6]  = '{32'h48,       32'h2222_2222, 1'b0, 1'b0, 1'b1, 32'h44,       32'h0,        c_nop,         1'b0, 2'd2, 1'b0};
    vecs[7]  = '{32'h48,       32'h3333_3333, 1'b0, 1'b1, 1'b1, 32'h44,       32'h0,        c_nop,         1'b0, 2'd2, 1'b0};
    vecs[8]  = '{32'h48,       32'h4444_4444, 1'b1, 1'b0, 1'b0, 32'h48,       32'h0,        c_nop,         1'b0, 2'd0, 1'b0};
    vecs[9]  = '{32'h4C,       32'h5555_5555, 1'b0, 1'b1, 1'b0, 32'h48,       32'h4C,       32'h5555_5555, 1'b1, 2'd0, 1'b0};
    vecs[10] = '{32'h4C,       32'h5A5A_5A5A, 1'b0, 1'b0, 1'b0, 32'h48,       32'h4C,       32'h5555_5555, 1'b1, 2'd1, 1'b0};
    vecs[11] = '{32'h80,       32'h6060_6060, 1'b1, 1'b0, 1'b1, 32'h80,       32'h0,        c_nop,         1'b0, 2'd2, 1'b0};
    vecs[12] = '{32'h84,       32'h6161_6161, 1'b0, 1'b0, 1'b0, 32'h80,       32'h0,        c_nop,         1'b0, 2'd1, 1'b0};
    vecs[13] = '{32'h84,       32'h6666_6666, 1'b1, 1'b1, 1'b0, 32'h84,       32'h84,       32'h6666_6666, 1'b1, 2'd0, 1'b0};

    #2 rst_i = 1'b0;
    #1 check_all("reset", 32'h0, 32'h0, c_nop, 1'b0, 2'd0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int i = 0; i < 14; i++)
      step($sformatf("vec%0d", i), vecs[i]);

    // PC+4 wraps from the top of the address space
    v = '{32'hFFFF_FFFC, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h88, 32'hA5A5_A5A5, 1'b1, 2'd0, 1'b0};
    step("wrap0", v);
    v = '{32'h0, 32'h7777_7777, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h7777_7777, 1'b1, 2'd0, 1'b0};
    step("wrap1", v);

    // Watchdog trips on the 8th consecutive stall and stays set
    for (int k = 1; k <= 8; k++) begin
      v = '{32'h100, 32'hBAD0_0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h7777_7777, 1'b1, 2'd1, (k == 8)};
      step($sformatf("wd%0d", k), v);
    end
    v = '{32'h4, 32'h8888_8888, 1'b1, 1'b1, 1'b0, 32'h4, 32'h4, 32'h8888_8888, 1'b1, 2'd0, 1'b1};
    step("wd_run", v);
    v = '{32'h8, 32'hBAD1_0000, 1'b0, 1'b0, 1'b0, 32'h4, 32'h4, 32'h8888_8888, 1'b1, 2'd1, 1'b1};
    step("wd_stall", v);

    // Asynchronous reset mid-cycle while stalled
    #3 rst_i = 1'b0;
    exp_scnt = 32'h0;
    exp_fcnt = 32'h0;
    #1 check_all("areset", 32'h0, 32'h0, c_nop, 1'b0, 2'd0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;
    v = '{32'h8, 32'h9999_9999, 1'b1, 1'b1, 1'b0, 32'h8, 32'h4, 32'h9999_9999, 1'b1, 2'd0, 1'b0};
    step("post_rst", v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ifid_pipe_reg.md
Name: ifid_pipe_reg

Overview:
- Consumer side of the hazard control interface. Applies PCWrite / IFIDWrite / IFFlush to the PC register and the IF/ID pipeline register.
- Sits between instruction fetch and decode in the 5-stage pipeline.
- Tracks pipeline condition with a small FSM.
- Flags runaway stalls through a sticky watchdog.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_STALL, 8, consecutive stall cycles that trip the watchdog (range 1..255).
- NOP_INSTR, 32'h0000_0000, instruction word inserted on flush.

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_i  input  1  reset, asynchronous, active-low.
- pc_next_i  input  32  next PC selected by fetch mux (PC+4 or branch target).
- instr_i  input  32  instruction read at pc_o.
- PCWrite_i  input  1  PC update enable from hazard unit.
- IFIDWrite_i  input  1  IF/ID update enable from hazard unit.
- IFFlush_i  input  1  IF/ID flush from hazard unit.
- pc_o  output  32  current PC to instruction memory.
- IFID_pc_o  output  32  registered pc_o+4 of the held instruction.
- IFID_instr_o  output  32  registered instruction to decode.
- IFID_valid_o  output  1  1 = IF/ID holds a real instruction, 0 = bubble.
- state_o  output  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH.
- stall_err_o  output  1  sticky watchdog flag.
- stall_cnt_o  output  32  total stall cycles (optional feature).
- flush_cnt_o  output  32  total flush cycles (optional feature).

Behaviour:
- Reset (rst_i=0, async):
  - pc_o=RESET_PC; IFID_pc_o=0; IFID_instr_o=NOP_INSTR; IFID_valid_o=0.
  - state_o=RUN; stall_err_o=0; internal stall run-length=0; stall_cnt_o=0; flush_cnt_o=0.
- Reset asserted mid-stall or mid-flush aborts immediately to these values. The first edge after release behaves as a normal cycle.
- PC register, each rising edge: PCWrite_i=1 -> pc_o<=pc_next_i; else hold. Independent of IFIDWrite_i and IFFlush_i.
- IF/ID register, each rising edge, priority high to low:
  - IFFlush_i=1 -> IFID_instr_o<=NOP_INSTR, IFID_valid_o<=0, IFID_pc_o<=0. Flush wins even when IFIDWrite_i=0.
  - IFIDWrite_i=1 -> IFID_instr_o<=instr_i, IFID_pc_o<=pc_o+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), IFID_valid_o<=1.
  - Otherwise hold all three.
- Latency: an instruction presented at cycle n appears on IFID_* at n+1. No combinational path from any input to any output.
- FSM, registered, next state from the current-cycle inputs:
  - IFFlush_i=1 -> FLUSH.
  - else PCWrite_i=0 and IFIDWrite_i=0 -> STALL.
  - else -> RUN.
  - Every transition among the 3 states is legal. Encoding 3 is unreachable; if entered, go to RUN on the next edge.
- Stall watchdog:
  - Run-length counter increments on each edge where next state is STALL; clears on any non-STALL next state.
  - Saturates at MAX_STALL.
  - On the edge where it reaches MAX_STALL, stall_err_o<=1. stall_err_o stays 1 until reset.
- Mixed enables (PCWrite_i=1, IFIDWrite_i=0, no flush): PC advances, IF/ID holds, state RUN. Tolerated, not flagged.

Optional Feature:
- Macro: IFID_PERF_CNT_EN.
- Defined:
  - stall_cnt_o increments on each edge entering or remaining in STALL.
  - flush_cnt_o increments on each edge entering or remaining in FLUSH.
  - Both are 32-bit, wrap 32'hFFFF_FFFF -> 0, and are cleared only by reset.
- Undefined: no counter registers are built; both ports are tied to 0. Port list is unchanged.

Test Plan:
- Reset release, RESET_PC=0x0, pc_next_i=pc_o+4, enables=1, instr_i=0x2001_0005 then 0x2002_0007 -> pc_o 0,4,8; IFID_instr_o 0x2001_0005 at cycle 1 with IFID_pc_o=4, valid=1; state RUN.
- Load-use stall: PCWrite_i=IFIDWrite_i=0 for 1 cycle at pc_o=8 -> pc_o holds 8, IFID holds, state_o=1 for one cycle, then RUN; stall_err_o=0.
- Branch flush: IFFlush_i=1, PCWrite_i=1, pc_next_i=0x40 -> next edge pc_o=0x40, IFID_instr_o=NOP_INSTR, valid=0, state FLUSH; with IFID_PERF_CNT_EN, flush_cnt_o=1.
- Flush during stall (IFFlush_i=1, IFIDWrite_i=0, PCWrite_i=0) -> IF/ID bubbled, pc_o held, state FLUSH.
- Watchdog, MAX_STALL=8: 7 stall cycles -> stall_err_o=0; 8th -> 1; resume RUN -> stays 1; rst_i pulse low -> 0.
- Wrap and async reset: pc_o=0xFFFF_FFFC with IFIDWrite_i=1 -> IFID_pc_o=0. rst_i low mid-cycle during STALL -> outputs return to reset values without waiting for a clock edge.
